// File: rtl/gf2_mult_ds.sv
// Digit-serial carry-less (GF(2) polynomial) multiplier. Consumes DIGIT bits of b
// per cycle and returns the unreduced 2*WIDTH-bit product over a valid/ready handshake.
module gf2_mult_ds #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] d,
  output logic               busy
);

  localparam int unsigned NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned BW   = NDIG * DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] d_q, d_d;
  logic [2*WIDTH-1:0] prod;
  logic [BW-1:0]      b_sh_q, b_sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               load;
  logic               last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
  end

  assign load = in_valid && in_ready;
  assign last = (state_q == RUN) && (cnt_q == CW'(NDIG - 1));
  assign d    = d_q;

  // Partial product of the current a_sh with the lowest digit of b_sh.
  always_comb begin
    prod = '0;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      if (b_sh_q[j]) prod = prod ^ (a_sh_q << j);
    end
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    if (load) begin
      a_sh_d = {{WIDTH{1'b0}}, a};
      b_sh_d = BW'(b);
      acc_d  = '0;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      acc_d  = acc_q ^ prod;
      a_sh_d = a_sh_q << DIGIT;
      b_sh_d = b_sh_q >> DIGIT;
      cnt_d  = cnt_q + CW'(1);
      if (last) d_d = acc_q ^ prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      d_q    <= '0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
    end
  end

endmodule
